// File: rtl/spi_slave.sv
// spi_slave -- SPI target peripheral on a RIB slave port.
//
// Full-duplex, MSB-first, 8-bit frames, all four CPOL/CPHA modes. SCLK, SS and
// MOSI are synchronised into the clk domain and edges are found by comparing
// each synchronised sample with the previous one, so clk must run at least
// 4x SCLK. The host must allow SYNC_STAGES+2 clk between SS falling and the
// first SCLK edge.
//
// Optional build macro: SPI_SLV_RXFIFO_EN. When defined, RX is an
// RX_FIFO_DEPTH-entry FIFO and STATUS[7:4] reports the fill count. When it is
// undefined, RX is a single-entry buffer and STATUS[7:4] reads 0.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   we_i            RIB write enable
//   addr_i          RIB address (offset decoded from addr_i[3:0])
//   data_i          RIB write data
//   data_o          RIB read data, combinational from addr_i
//   spi_sclk        SPI clock from host
//   spi_ss          chip select, active-low
//   spi_mosi        host -> slave data
//   spi_miso        slave -> host data
//   spi_miso_oe     MISO output enable (SS asserted and CTRL.en set)
//   int_sig_o       level interrupt: (rx_ie & rx_valid) | overrun, registered
//
// Register map (offset = addr_i[3:0]):
//   0x0 CTRL   rw  [0]en [1]cpol [2]cpha [3]rx_ie
//   0x4 STATUS     [0]rx_valid [1]tx_empty [2]overrun [3]busy [7:4]rx count
//                  write: data_i[0]=1 pops one RX byte, data_i[2]=1 clears overrun
//   0x8 TXDATA wo  [7:0]
//   0xC RXDATA ro  [7:0] head byte (0 when empty), no read side effect
//
// RIB handshake: a write is a single-cycle strobe (we_i high for one clk with
// addr_i/data_i valid); there is no backpressure. Reads are combinational.

module spi_slave #(
  parameter int SYNC_STAGES   = 2,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        spi_sclk,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        int_sig_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_prev, ss_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;   // SS idles deasserted
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Control register and bus decode
  // --------------------------------------------------------------------------
  logic ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_rx_ie;
  logic wr_ctrl, wr_stat, wr_tx, rx_pop;

  assign wr_ctrl = we_i && (addr_i[3:0] == 4'h0);
  assign wr_stat = we_i && (addr_i[3:0] == 4'h4);
  assign wr_tx   = we_i && (addr_i[3:0] == 4'h8);
  assign rx_pop  = wr_stat && data_i[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en    <= 1'b0;
      ctrl_cpol  <= 1'b0;
      ctrl_cpha  <= 1'b0;
      ctrl_rx_ie <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en    <= data_i[0];
      ctrl_cpol  <= data_i[1];
      ctrl_cpha  <= data_i[2];
      ctrl_rx_ie <= data_i[3];
    end
  end

  // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;

  assign sclk_edge   = sclk_s ^ sclk_prev;
  assign lead_edge   = sclk_edge && (sclk_prev == ctrl_cpol);
  assign trail_edge  = sclk_edge && (sclk_s == ctrl_cpol);
  assign sample_edge = ctrl_cpha ? trail_edge : lead_edge;
  assign shift_edge  = ctrl_cpha ? lead_edge  : trail_edge;
  assign ss_fall     = ss_prev && !ss_s;
  assign ss_rise     = !ss_prev && ss_s;

  // --------------------------------------------------------------------------
  // Frame FSM and shift registers
  // --------------------------------------------------------------------------
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, tx_hold;
  logic       tx_empty;
  logic       frame_start, rx_push;
  logic [7:0] rx_byte, tx_next;

  assign frame_start = (state == IDLE) && ctrl_en && ss_fall;
  assign rx_push     = (state == ACTIVE) && ctrl_en && !ss_rise &&
                       sample_edge && (bit_cnt == 3'd7);
  assign rx_byte     = {rx_shift[6:0], mosi_s};
  assign tx_next     = tx_empty ? 8'h00 : tx_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      tx_shift <= 8'h00;
      tx_hold  <= 8'h00;
      tx_empty <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state    <= ACTIVE;
            tx_shift <= tx_next;
            bit_cnt  <= 3'd0;
          end
        end
        ACTIVE: begin
          if (!ctrl_en || ss_rise) begin
            state   <= IDLE;     // any partial byte is abandoned
            bit_cnt <= 3'd0;
          end else if (sample_edge) begin
            rx_shift <= rx_byte;
            if (bit_cnt == 3'd7) begin
              bit_cnt  <= 3'd0;
              tx_shift <= tx_next;   // next byte of a back-to-back frame
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else if (shift_edge && (bit_cnt != 3'd0)) begin
            // With bit_cnt==0 the shift edge is either the CPHA=1 launch of
            // bit 7 (already on MISO) or the CPHA=0 trailing edge right after
            // a reload; shifting there would lose bit 7.
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase

      // A load consumes tx_hold; a TXDATA write in the same cycle refills it.
      if (frame_start || rx_push) tx_empty <= 1'b1;
      if (wr_tx) begin
        tx_hold  <= data_i[7:0];
        tx_empty <= 1'b0;
      end
    end
  end

  assign spi_miso_oe = (state == ACTIVE) && ctrl_en;
  assign spi_miso    = spi_miso_oe && tx_shift[7];

  // --------------------------------------------------------------------------
  // RX storage
  // --------------------------------------------------------------------------
  logic       rx_valid, rx_full, overrun;
  logic [7:0] rx_head;
  logic [3:0] rx_cnt4;

`ifdef SPI_SLV_RXFIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0]   RX_FULL_CNT = (AW+1)'(RX_FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  logic [7:0]    rx_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   rx_count;
  logic          do_push, do_pop;

  assign do_pop  = rx_pop && (rx_count != '0);
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign do_push = rx_push && ((rx_count != RX_FULL_CNT) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) rx_mem[i] <= 8'h00;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (do_push) begin
        rx_mem[rx_wr_ptr] <= rx_byte;
        rx_wr_ptr         <= rx_wr_ptr + PTR_ONE;
      end
      if (do_pop) rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  assign rx_valid = (rx_count != '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_head  = rx_valid ? rx_mem[rx_rd_ptr] : 8'h00;
  assign rx_cnt4  = 4'(rx_count);
`else
  logic [7:0] rx_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf   <= 8'h00;
      rx_valid <= 1'b0;
    end else if (rx_push && (!rx_valid || rx_pop)) begin
      rx_buf   <= rx_byte;
      rx_valid <= 1'b1;
    end else if (rx_pop) begin
      rx_valid <= 1'b0;
    end
  end

  assign rx_full = rx_valid;
  assign rx_head = rx_valid ? rx_buf : 8'h00;
  assign rx_cnt4 = 4'h0;
`endif

  // Overrun is sticky; a push into a full store only survives if a pop frees
  // room in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (rx_push && rx_full && !rx_pop) begin
      overrun <= 1'b1;
    end else if (wr_stat && data_i[2]) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_sig_o <= 1'b0;
    else     int_sig_o <= (ctrl_rx_ie && rx_valid) || overrun;
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic busy;
  assign busy = (state == ACTIVE);

  always_comb begin
    data_o = 32'h0;
    case (addr_i[3:0])
      4'h0:    data_o[3:0] = {ctrl_rx_ie, ctrl_cpha, ctrl_cpol, ctrl_en};
      4'h4:    data_o[7:0] = {rx_cnt4, busy, overrun, tx_empty, rx_valid};
      4'hC:    data_o[7:0] = rx_head;
      default: data_o = 32'h0;
    endcase
  end

  // Upper address/data bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], data_i[31:8]};

endmodule
